// File: rtl/psg_pan_mixer.sv
// Time-multiplexed stereo pan mixer for NCH unsigned PSG channels.
// One channel is accumulated per clock, then left-justified, gain-shifted and saturated.
module psg_pan_mixer #(
  parameter int NCH   = 3,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce_sample,
  input  logic [NCH*IN_W-1:0] ch_in,
  input  logic [2*NCH-1:0]    pan,
  input  logic                mono,
  input  logic [1:0]          gain,
  output logic [OUT_W-1:0]    audio_l,
  output logic [OUT_W-1:0]    audio_r,
  output logic                sample_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int ACC_W = IN_W + $clog2(NCH);
  localparam int IDX_W = $clog2(NCH);
  localparam int SW    = OUT_W + 3;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

  state_t              r_state;
  logic [NCH*IN_W-1:0] r_ch;
  logic [2*NCH-1:0]    r_pan;
  logic                r_mono;
  logic [1:0]          r_gain;
  logic [IDX_W-1:0]    r_idx;
  logic [ACC_W-1:0]    r_acc_l, r_acc_r;
  logic [OUT_W-1:0]    r_audio_l, r_audio_r;
  logic                r_valid, r_busy, r_overrun;

  logic [IN_W-1:0]     w_ch_k;
  logic [1:0]          w_pan_k;
  logic                w_add_l, w_add_r;

  assign w_ch_k  = r_ch[int'(r_idx)*IN_W +: IN_W];
  assign w_pan_k = r_pan[2*int'(r_idx) +: 2];
  assign w_add_l = r_mono | w_pan_k[0];
  assign w_add_r = r_mono | w_pan_k[1];

  // Justify to OUT_W, shift by gain with 3 guard bits, clamp on any guard bit set.
  function automatic logic [OUT_W-1:0] scale(input logic [ACC_W-1:0] acc, input logic [1:0] g);
    logic [SW-1:0] s;
    s = SW'(acc) << (OUT_W - ACC_W);
    s = s << g;
    if (|s[SW-1:OUT_W]) return '1;
    return s[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ch      <= '0;
      r_pan     <= '0;
      r_mono    <= 1'b0;
      r_gain    <= '0;
      r_idx     <= '0;
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_audio_l <= '0;
      r_audio_r <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (ce_sample && r_busy) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (ce_sample) begin
          r_ch    <= ch_in;
          r_pan   <= pan;
          r_mono  <= mono;
          r_gain  <= gain;
          r_acc_l <= '0;
          r_acc_r <= '0;
          r_idx   <= '0;
          r_busy  <= 1'b1;
          r_state <= ACCUM;
        end
        ACCUM: begin
          if (w_add_l) r_acc_l <= r_acc_l + ACC_W'(w_ch_k);
          if (w_add_r) r_acc_r <= r_acc_r + ACC_W'(w_ch_k);
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDX_W'(NCH - 1)) r_state <= SCALE;
        end
        // Outputs are loaded here so they and the valid pulse are visible during OUT.
        SCALE: begin
          r_audio_l <= scale(r_acc_l, r_gain);
          r_audio_r <= scale(r_acc_r, r_gain);
          r_valid   <= 1'b1;
          r_state   <= OUT;
        end
        OUT: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign audio_l      = r_audio_l;
  assign audio_r      = r_audio_r;
  assign sample_valid = r_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_psg_pan_mixer.sv
// Bench for psg_pan_mixer: vector table through a scoreboard, plus timing,
// overrun, reset-abort and a reduced-parameter instance.
module tb_psg_pan_mixer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, ce = 1'b0, mono = 1'b0;
  logic [23:0] ch = '0;
  logic [5:0]  pan = '0;
  logic [1:0]  gain = '0;
  logic [15:0] al, ar;
  logic        sv, busy, ovr;

  logic        ce2 = 1'b0;
  logic [7:0]  ch2 = '0;
  logic [3:0]  pan2 = '0;
  logic [7:0]  al2, ar2;
  logic        sv2, busy2, ovr2;

  psg_pan_mixer dut (
    .clk_sys(clk), .reset(reset), .ce_sample(ce), .ch_in(ch), .pan(pan),
    .mono(mono), .gain(gain), .audio_l(al), .audio_r(ar),
    .sample_valid(sv), .busy(busy), .overrun(ovr));

  psg_pan_mixer #(.NCH(2), .IN_W(4), .OUT_W(8)) dut2 (
    .clk_sys(clk), .reset(reset), .ce_sample(ce2), .ch_in(ch2), .pan(pan2),
    .mono(1'b0), .gain(2'd0), .audio_l(al2), .audio_r(ar2),
    .sample_valid(sv2), .busy(busy2), .overrun(ovr2));

  typedef struct {
    logic [23:0] ch;
    logic [5:0]  pan;
    logic        mono;
    logic [1:0]  gain;
    logic [15:0] el, er;
  } vec_t;

  typedef struct { logic [15:0] l, r; } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain timeout: %0d samples still pending, expected 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  // Scoreboard consumer: every sample_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && sv) begin
      if (sb.size() == 0) begin
        chk("unexpected sample_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("audio_l", int'(al), int'(e.l));
        chk("audio_r", int'(ar), int'(e.r));
      end
    end
  end

  task automatic run2(input logic [7:0] c, input logic [3:0] p,
                      input logic [7:0] el, input logic [7:0] er);
    int found = -1;
    logic [7:0] gl = '0, gr = '0;
    ch2 = c; pan2 = p; ce2 = 1'b1;
    tick();
    ce2 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (sv2 && found < 0) begin
        found = k; gl = al2; gr = ar2;
      end
      tick();
    end
    chk("nch2 valid latency", found, 4);
    chk("nch2 audio_l", int'(gl), int'(el));
    chk("nch2 audio_r", int'(gr), int'(er));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[9];
    tv[0] = '{24'h204080, 6'b101101, 1'b0, 2'd0, 16'h3000, 16'h1800};
    tv[1] = '{24'h204080, 6'b101101, 1'b1, 2'd0, 16'h3800, 16'h3800};
    tv[2] = '{24'hFFFFFF, 6'b111111, 1'b0, 2'd1, 16'hFFFF, 16'hFFFF};
    tv[3] = '{24'hFFFFFF, 6'b111111, 1'b0, 2'd0, 16'hBF40, 16'hBF40};
    tv[4] = '{24'h123456, 6'b000000, 1'b0, 2'd2, 16'h0000, 16'h0000};
    tv[5] = '{24'h010203, 6'b110110, 1'b0, 2'd3, 16'h0600, 16'h0800};
    tv[6] = '{24'h00007F, 6'b000001, 1'b0, 2'd3, 16'hFE00, 16'h0000};
    tv[7] = '{24'h000080, 6'b000011, 1'b0, 2'd3, 16'hFFFF, 16'hFFFF};
    tv[8] = '{24'h123456, 6'b000000, 1'b1, 2'd0, 16'h2700, 16'h2700};

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset audio_l", int'(al), 0);
    chk("reset audio_r", int'(ar), 0);
    chk("reset sample_valid", int'(sv), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset overrun", int'(ovr), 0);
    tick();

    // Table vectors; inputs are scrambled while busy to prove the snapshot.
    for (int i = 0; i < 9; i++) begin
      ch = tv[i].ch; pan = tv[i].pan; mono = tv[i].mono; gain = tv[i].gain;
      ce = 1'b1;
      sb.push_back('{tv[i].el, tv[i].er});
      tick();
      ce = 1'b0;
      ch = 24'($urandom); pan = 6'($urandom); mono = 1'($urandom); gain = 2'($urandom);
      wait_drain();
    end

    // Timing, overrun on ce during busy, and re-accept right after OUT.
    ch = tv[0].ch; pan = tv[0].pan; mono = 1'b0; gain = 2'd0;
    for (int k = 0; k <= 12; k++) begin
      ce = (k == 0 || k == 2 || k == 6);
      if (k == 0 || k == 6) sb.push_back('{16'h3000, 16'h1800});
      @(negedge clk);
      chk($sformatf("sample_valid T+%0d", k), int'(sv), int'(k == 5 || k == 11));
      chk($sformatf("busy T+%0d", k), int'(busy), int'((k >= 1 && k <= 5) || (k >= 7 && k <= 11)));
      chk($sformatf("overrun T+%0d", k), int'(ovr), int'(k >= 3));
      tick();
    end
    ce = 1'b0;
    wait_drain();

    // Reset during ACCUM aborts the sample and clears the sticky flag.
    ch = tv[3].ch; pan = tv[3].pan; gain = 2'd0;
    for (int k = 0; k <= 10; k++) begin
      ce = (k == 0);
      reset = (k == 3);
      if (k == 3) sb.delete();
      @(negedge clk);
      if (k == 4) begin
        chk("abort audio_l", int'(al), 0);
        chk("abort audio_r", int'(ar), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort overrun", int'(ovr), 0);
      end
      tick();
    end

    // Reset wins over a simultaneous ce_sample.
    reset = 1'b1; ce = 1'b1;
    tick();
    reset = 1'b0; ce = 1'b0;
    @(negedge clk);
    chk("reset priority busy", int'(busy), 0);
    tick();

    // Clean restart after the abort.
    ch = tv[5].ch; pan = tv[5].pan; mono = tv[5].mono; gain = tv[5].gain;
    ce = 1'b1;
    sb.push_back('{tv[5].el, tv[5].er});
    tick();
    ce = 1'b0;
    wait_drain();

    // Reduced parameters: NCH=2, IN_W=4, OUT_W=8.
    run2(8'hFF, 4'b1111, 8'hF0, 8'hF0);
    run2(8'hFF, 4'b0000, 8'h00, 8'h00);
    run2(8'h53, 4'b1001, 8'h18, 8'h28);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
